// File: rtl/lmc1992_rx.sv
// LMC1992 volume/tone controller seen from the MicroWire link: shifts in
// masked serial bits, then checks and applies each 11-bit command word.
module lmc1992_rx #(
   parameter logic [1:0]  DEV_ADDR = 2'b10,
   parameter int unsigned MIN_BITS = 11
) (
   input  logic       clk32,
   input  logic       reset,
   input  logic       mw_bit_stb,
   input  logic       mw_clk,
   input  logic       mw_data,
   input  logic       mw_done,
   output logic [5:0] master_vol,
   output logic [4:0] left_vol,
   output logic [4:0] right_vol,
   output logic [3:0] bass,
   output logic [3:0] treble,
   output logic [1:0] mix,
   output logic       cmd_stb,
   output logic       frame_err,
   output logic       busy
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      DECODE = 2'd2
   } state_t;

   localparam logic [4:0] MIN_CNT = 5'(MIN_BITS);

   localparam logic [2:0] FN_MIX    = 3'b000;
   localparam logic [2:0] FN_BASS   = 3'b001;
   localparam logic [2:0] FN_TREBLE = 3'b010;
   localparam logic [2:0] FN_MASTER = 3'b011;
   localparam logic [2:0] FN_RIGHT  = 3'b100;
   localparam logic [2:0] FN_LEFT   = 3'b101;

   state_t      state;
   logic [10:0] shreg;
   logic [4:0]  count;
   logic        done_d;
   logic        done_rise;
   logic        bit_vld;

   logic        vld_p1;
   logic        err_p1;
   logic [2:0]  func_p1;
   logic [5:0]  val_p1;

   function automatic logic [5:0] sat_master(input logic [5:0] v);
      return (v > 6'd40) ? 6'd40 : v;
   endfunction

   function automatic logic [4:0] sat_vol(input logic [4:0] v);
      return (v > 5'd20) ? 5'd20 : v;
   endfunction

   function automatic logic [3:0] sat_tone(input logic [3:0] v);
      return (v > 4'd12) ? 4'd12 : v;
   endfunction

   assign done_rise = mw_done & ~done_d;
   assign bit_vld   = mw_bit_stb & mw_clk;

   // Stage p0: bit assembly and frame evaluation
   always_ff @(posedge clk32) begin
      if (reset) begin
         state   <= IDLE;
         shreg   <= '0;
         count   <= '0;
         done_d  <= 1'b0;
         busy    <= 1'b0;
         vld_p1  <= 1'b0;
         err_p1  <= 1'b0;
         func_p1 <= '0;
         val_p1  <= '0;
      end else begin
         done_d <= mw_done;
         vld_p1 <= 1'b0;
         err_p1 <= 1'b0;
         case (state)
            IDLE: begin
               if (bit_vld) begin
                  shreg <= {shreg[9:0], mw_data};
                  count <= 5'd1;
                  state <= SHIFT;
                  busy  <= 1'b1;
               end
            end
            SHIFT: begin
               if (bit_vld) begin
                  shreg <= {shreg[9:0], mw_data};
                  count <= (count == 5'd31) ? count : count + 5'd1;
               end
               if (done_rise) begin
                  state <= DECODE;
                  busy  <= 1'b0;
               end
            end
            DECODE: begin
               // Function codes 110/111 are undefined and rejected like a bad address.
               if ((count < MIN_CNT) || (shreg[10:9] != DEV_ADDR) || (shreg[8:7] == 2'b11)) begin
                  err_p1 <= 1'b1;
               end else begin
                  vld_p1 <= 1'b1;
               end
               func_p1 <= shreg[8:6];
               val_p1  <= shreg[5:0];
               shreg   <= '0;
               count   <= '0;
               state   <= IDLE;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   // Stage p1: apply the decoded command to the mixer settings
   always_ff @(posedge clk32) begin
      if (reset) begin
         master_vol <= 6'd40;
         left_vol   <= 5'd20;
         right_vol  <= 5'd20;
         bass       <= 4'd6;
         treble     <= 4'd6;
         mix        <= 2'b01;
         cmd_stb    <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         cmd_stb   <= vld_p1;
         frame_err <= err_p1;
         if (vld_p1) begin
            case (func_p1)
               FN_MIX:    mix        <= val_p1[1:0];
               FN_BASS:   bass       <= sat_tone(val_p1[3:0]);
               FN_TREBLE: treble     <= sat_tone(val_p1[3:0]);
               FN_MASTER: master_vol <= sat_master(val_p1);
               FN_RIGHT:  right_vol  <= sat_vol(val_p1[4:0]);
               FN_LEFT:   left_vol   <= sat_vol(val_p1[4:0]);
               default:   ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_lmc1992_rx.sv
// Randomised MicroWire frames against a frame-level model of the LMC1992 receiver.
module tb_lmc1992_rx;

   logic       clk32 = 1'b0;
   logic       reset = 1'b1;
   logic       mw_bit_stb = 1'b0;
   logic       mw_clk = 1'b0;
   logic       mw_data = 1'b0;
   logic       mw_done = 1'b0;
   logic [5:0] master_vol;
   logic [4:0] left_vol;
   logic [4:0] right_vol;
   logic [3:0] bass;
   logic [3:0] treble;
   logic [1:0] mix;
   logic       cmd_stb;
   logic       frame_err;
   logic       busy;

   lmc1992_rx dut (
      .clk32      (clk32),
      .reset      (reset),
      .mw_bit_stb (mw_bit_stb),
      .mw_clk     (mw_clk),
      .mw_data    (mw_data),
      .mw_done    (mw_done),
      .master_vol (master_vol),
      .left_vol   (left_vol),
      .right_vol  (right_vol),
      .bass       (bass),
      .treble     (treble),
      .mix        (mix),
      .cmd_stb    (cmd_stb),
      .frame_err  (frame_err),
      .busy       (busy)
   );

   always #5 clk32 = ~clk32;

   typedef struct {
      int t;
      int kind;   // 0 apply, 1 reject, 2 busy on, 3 busy off
      int sel;
      int val;
   } ev_t;

   ev_t evq[$];
   bit  bits_q[$];
   bit  sd[$];
   bit  sm[$];

   int total = 0;
   int bad = 0;
   int cyc = 0;
   bit skip = 1'b1;

   int m_master = 40, m_left = 20, m_right = 20, m_bass = 6, m_treble = 6, m_mix = 1;
   int m_busy = 0;
   int cmd_cnt = 0, err_cnt = 0, last_cmd_cyc = -1, last_ts = 0;

   always @(posedge clk32) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push_ev(input int t, input int kind, input int sel, input int val);
      ev_t e;
      e.t = t; e.kind = kind; e.sel = sel; e.val = val;
      evq.push_back(e);
   endtask

   task automatic model_defaults();
      m_master = 40; m_left = 20; m_right = 20; m_bass = 6; m_treble = 6; m_mix = 1;
      m_busy = 0;
   endtask

   task automatic apply(input int sel, input int v);
      case (sel)
         0: m_mix = v;
         1: m_bass = v;
         2: m_treble = v;
         3: m_master = v;
         4: m_right = v;
         5: m_left = v;
         default: ;
      endcase
   endtask

   function automatic int min_i(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   // Frame closed by a done edge sampled at clock edge ts.
   task automatic close_model(input int ts);
      int n, word, addr, fn, v, start;
      n = bits_q.size();
      if (n == 0) return;
      push_ev(ts, 3, 0, 0);
      word = 0;
      start = (n > 11) ? n - 11 : 0;
      for (int i = start; i < n; i++) word = word * 2 + int'(bits_q[i]);
      addr = word / 512;
      fn = (word / 64) % 8;
      v = word % 64;
      if (n < 11 || addr != 2 || fn > 5) begin
         push_ev(ts + 2, 1, 0, 0);
      end else begin
         case (fn)
            0: v = v % 4;
            1, 2: v = min_i(v % 16, 12);
            3: v = min_i(v, 40);
            default: v = min_i(v % 32, 20);
         endcase
         push_ev(ts + 2, 0, fn, v);
      end
      bits_q.delete();
      last_ts = ts;
   endtask

   always @(negedge clk32) begin : cmp
      int ec;
      int ee;
      ec = 0;
      ee = 0;
      if (!skip) begin
         for (int i = evq.size() - 1; i >= 0; i--) begin
            if (evq[i].t == cyc) begin
               case (evq[i].kind)
                  0: begin ec = 1; apply(evq[i].sel, evq[i].val); end
                  1: ee = 1;
                  2: m_busy = 1;
                  default: m_busy = 0;
               endcase
               evq.delete(i);
            end
         end
         chk("master_vol", int'(master_vol), m_master);
         chk("left_vol", int'(left_vol), m_left);
         chk("right_vol", int'(right_vol), m_right);
         chk("bass", int'(bass), m_bass);
         chk("treble", int'(treble), m_treble);
         chk("mix", int'(mix), m_mix);
         chk("cmd_stb", int'(cmd_stb), ec);
         chk("frame_err", int'(frame_err), ee);
         chk("busy", int'(busy), m_busy);
      end
      if (cmd_stb) begin
         cmd_cnt++;
         last_cmd_cyc = cyc;
      end
      if (frame_err) err_cnt++;
   end

   task automatic tick();
      @(posedge clk32);
      #1;
   endtask

   task automatic do_reset(input int hold);
      tick();
      reset = 1'b1;
      skip = 1'b1;
      mw_bit_stb = 1'b0; mw_clk = 1'b0; mw_data = 1'b0; mw_done = 1'b0;
      evq.delete();
      bits_q.delete();
      model_defaults();
      repeat (hold) tick();
      reset = 1'b0;
      tick();
      skip = 1'b0;
   endtask

   task automatic load_word(input logic [31:0] v, input int n, input logic [31:0] m);
      sd.delete();
      sm.delete();
      for (int i = 0; i < n; i++) begin
         sd.push_back(v[n-1-i]);
         sm.push_back(m[n-1-i]);
      end
   endtask

   // Drives the queued slots; last_done raises mw_done with the final slot.
   task automatic run_frame(input bit last_done, input bit close);
      for (int i = 0; i < sd.size(); i++) begin
         tick();
         mw_bit_stb = 1'b1;
         mw_clk = sm[i];
         mw_data = sd[i];
         if (sm[i]) begin
            if (bits_q.size() == 0) push_ev(cyc + 1, 2, 0, 0);
            bits_q.push_back(sd[i]);
         end
         if (last_done && i == sd.size() - 1) begin
            mw_done = 1'b1;
            close_model(cyc + 1);
         end
         tick();
         mw_bit_stb = 1'b0; mw_clk = 1'b0; mw_data = 1'b0;
         repeat ($urandom_range(0, 3)) tick();
      end
      if (last_done) begin
         tick();
         mw_done = 1'b0;
      end else if (close) begin
         tick();
         mw_done = 1'b1;
         close_model(cyc + 1);
         tick();
         tick();
         mw_done = 1'b0;
      end
      repeat (5) tick();
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "timeout");
   end

   initial begin : main
      int e0, c0, nvalid, nv_total;
      logic [31:0] vb;
      logic [1:0] a;
      logic [2:0] fn;
      logic [5:0] vv;
      bit ld;

      repeat (3) tick();
      reset = 1'b0;
      tick();
      skip = 1'b0;
      tick();

      chk("rst_master", int'(master_vol), 40);
      chk("rst_left", int'(left_vol), 20);
      chk("rst_right", int'(right_vol), 20);
      chk("rst_bass", int'(bass), 6);
      chk("rst_treble", int'(treble), 6);
      chk("rst_mix", int'(mix), 1);
      chk("rst_busy", int'(busy), 0);
      chk("rst_strobes", cmd_cnt + err_cnt, 0);

      load_word(32'h4E8, 11, 32'h7FF);
      run_frame(1'b0, 1'b1);
      chk("t2_master", int'(master_vol), 40);
      chk("t2_cmd_count", cmd_cnt, 1);
      chk("t2_latency", last_cmd_cyc - last_ts, 2);

      load_word(32'h4FF, 11, 32'h7FF);
      run_frame(1'b0, 1'b1);
      chk("t3_master_clamp", int'(master_vol), 40);
      load_word(32'h54F, 11, 32'h7FF);
      run_frame(1'b0, 1'b1);
      chk("t3_left", int'(left_vol), 15);
      load_word(32'h45F, 11, 32'h7FF);
      run_frame(1'b0, 1'b1);
      chk("t3_bass_clamp", int'(bass), 12);

      e0 = err_cnt;
      c0 = cmd_cnt;
      load_word(32'h2E8, 11, 32'h7FF);
      run_frame(1'b0, 1'b1);
      chk("t4_addr_err", err_cnt - e0, 1);
      load_word(32'h0E8, 9, 32'h1FF);
      run_frame(1'b0, 1'b1);
      chk("t4_short_err", err_cnt - e0, 2);
      chk("t4_no_cmd", cmd_cnt - c0, 0);
      chk("t4_left_kept", int'(left_vol), 15);
      chk("t4_bass_kept", int'(bass), 12);

      // 0x4D4 decodes as function 011 with value 20.
      load_word(32'hB4D4, 16, 32'hF7FF);
      run_frame(1'b1, 1'b1);
      chk("t5_master", int'(master_vol), 20);
      chk("t5_right", int'(right_vol), 20);

      load_word(32'h2A, 6, 32'h3F);
      run_frame(1'b0, 1'b0);
      c0 = cmd_cnt;
      e0 = err_cnt;
      do_reset(2);
      repeat (4) tick();
      chk("t6_no_strobe", (cmd_cnt - c0) + (err_cnt - e0), 0);
      chk("t6_master_rst", int'(master_vol), 40);
      load_word(32'h48C, 11, 32'h7FF);
      run_frame(1'b0, 1'b1);
      chk("t6_treble", int'(treble), 12);
      chk("t6_one_cmd", cmd_cnt - c0, 1);

      for (int f = 0; f < 48; f++) begin
         nvalid = $urandom_range(7, 18);
         a = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b10;
         fn = 3'($urandom_range(0, 7));
         vv = 6'($urandom_range(0, 63));
         vb = ($urandom() << 11) | {21'b0, a, fn, vv};
         sd.delete();
         sm.delete();
         nv_total = 0;
         for (int i = nvalid - 1; i >= 0; i--) begin
            if ($urandom_range(0, 4) == 0) begin
               sd.push_back(1'($urandom_range(0, 1)));
               sm.push_back(1'b0);
            end
            sd.push_back(vb[i]);
            sm.push_back(1'b1);
            nv_total++;
         end
         ld = (nv_total > 1) && ($urandom_range(0, 1) == 1);
         run_frame(ld, 1'b1);
      end

      repeat (5) tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
